edit_sequencer: RTL and testbench
=================================

// Module: edit_sequencer
// PURPOSE
//  Front-panel controller that sequences screen selection and Edit Mode for the clock datapaths
//  (time, date, time-zone hours/minutes/sign). Converts raw active-low buttons into one-cycle
//  commands. Drives screen/EditMode/EditPos for the datapaths; per-screen cursor ranges; auto-exit.
//  Sits between the button synchronisers and every datapath manager.
// PARAMETERS
//  TIMEOUT    1000  idle cycles in EDIT before automatic return to VIEW (>=2)
//  BLINK_DIV  250   cycles per half-period of the Blink cursor output (>=1)
// PORTS
//  clk       in   1  main clock
//  reset     in   1  asynchronous, active-low reset
//  KeyMode   in   1  active-low, pre-synchronised: next screen (VIEW) / leave edit (EDIT)
//  KeyEdit   in   1  active-low: enter Edit Mode on current screen
//  KeyLeft   in   1  active-low: cursor toward lower EditPos
//  KeyRight  in   1  active-low: cursor toward higher EditPos
//  KeyPlus   in   1  active-low raw plus button
//  KeyMinus  in   1  active-low raw minus button
//  screen    out  2  current screen: 0 time, 1 date, 2 time zone, 3 info (view-only)
//  EditMode  out  1  high while in EDIT
//  EditPos   out  3  cursor position, 0 = leftmost hex
//  PlusN     out  1  active-low one-cycle pulse to datapaths (EDIT only)
//  MinusN    out  1  active-low one-cycle pulse to datapaths (EDIT only)
//  Blink     out  1  cursor blink, toggles every BLINK_DIV cycles in EDIT, forced 1 in VIEW
// BEHAVIOUR
//  - Reset (async, active-low): state VIEW, screen=0, EditMode=0, EditPos=0, PlusN=1, MinusN=1,
//    Blink=1, timeout/blink counters=0, all key history regs=1 (released).
//  - Press = falling edge: key low now, high in previous cycle (one history reg per key).
//    Held key yields exactly one press. Outputs registered: 1-cycle latency from first low sample.
//  - Cursor ranges [min,max]: screen0 [2,7], screen1 [0,7], screen2 [1,4], screen3 none.
//  - FSM states VIEW, EDIT. EditMode = (state==EDIT).
//    VIEW: Mode press -> screen+1 mod 4 (3->0), EditPos=0. Edit press on screen 0..2 -> EDIT,
//      EditPos=min, counters cleared. Edit press on screen3 ignored. Left/Right/Plus/Minus ignored.
//    EDIT: Right press -> EditPos+1, max wraps to min. Left press -> EditPos-1, min wraps to max.
//      Plus press -> PlusN=0 for one cycle; Minus press -> MinusN=0 for one cycle.
//      Mode or Edit press -> VIEW, EditPos=0, screen unchanged.
//      Timeout counter +1 per cycle, cleared on any press; reaching TIMEOUT-1 -> VIEW next edge.
//  - Simultaneous presses, same cycle, priority: Mode/Edit exit > Left+Right (both ignored) >
//    single Left/Right > Plus/Minus. Plus+Minus together: neither pulse. Cursor move and
//    Plus/Minus in same cycle: move taken, pulse suppressed (pulse must target a stable EditPos).
//    Any press, even suppressed, clears timeout counter.
//  - screen never changes while EditMode=1; EditPos always inside current range in EDIT.
//  - Blink: counter runs only in EDIT; reset to 0 and Blink=1 on entry and on every cursor move.
//  - Reset asserted mid-edit: immediate return to reset values; pending pulses dropped.
//  - Counters sized $clog2(TIMEOUT) / $clog2(BLINK_DIV); no overflow beyond terminal count.
// TESTING
//  1 Reset, pulse KeyMode low 1 cycle x4 -> screen 1,2,3,0; EditMode stays 0; PlusN/MinusN stay 1.
//  2 screen=2, KeyEdit press -> EditMode=1, EditPos=1; KeyRight x4 -> 2,3,4,1; KeyLeft -> 4.
//  3 EDIT, hold KeyPlus low 20 cycles -> PlusN low exactly 1 cycle, 1 cycle after first low sample.
//  4 EDIT, KeyPlus+KeyMinus same cycle -> no pulses; KeyRight+KeyPlus same cycle -> EditPos+1, PlusN=1.
//  5 TIMEOUT=16, EDIT, no keys -> EditMode falls after 16 cycles; press at cycle 10 restarts count.
//  6 screen=3 KeyEdit -> stays VIEW; EDIT on screen0 pos 5, reset low mid-cycle -> all outputs reset.

Source files
------------

// File: rtl/edit_sequencer.sv
// Front-panel sequencer: button falling-edge detect, VIEW/EDIT FSM, cursor, blink and idle auto-exit.
// All outputs registered, 1 cycle after the first low key sample; no backpressure (single-cycle commands).
module edit_sequencer #(
  parameter int TIMEOUT   = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       KeyMode,
  input  logic       KeyEdit,
  input  logic       KeyLeft,
  input  logic       KeyRight,
  input  logic       KeyPlus,
  input  logic       KeyMinus,
  output logic [1:0] screen,
  output logic       EditMode,
  output logic [2:0] EditPos,
  output logic       PlusN,
  output logic       MinusN,
  output logic       Blink
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {
    ST_VIEW = 1'b0,
    ST_EDIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    screen_q, screen_d;
  logic [2:0]    pos_q, pos_d;
  logic          plus_n_q, plus_n_d;
  logic          minus_n_q, minus_n_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic [5:0]    key_q, key_d;

  logic [5:0] key_raw;
  logic [5:0] press;
  logic       p_mode, p_edit, p_left, p_right, p_plus, p_minus;
  logic       any_press;
  logic [2:0] cur_min, cur_max;

  assign key_raw = {KeyMode, KeyEdit, KeyLeft, KeyRight, KeyPlus, KeyMinus};
  assign key_d   = key_raw;
  // A press is high-to-low between consecutive samples; a held key therefore fires once.
  assign press   = key_q & ~key_raw;
  assign {p_mode, p_edit, p_left, p_right, p_plus, p_minus} = press;
  assign any_press = |press;

  always_comb begin
    cur_min = 3'd0;
    cur_max = 3'd0;
    case (screen_q)
      2'd0:    begin cur_min = 3'd2; cur_max = 3'd7; end
      2'd1:    begin cur_min = 3'd0; cur_max = 3'd7; end
      2'd2:    begin cur_min = 3'd1; cur_max = 3'd4; end
      default: begin cur_min = 3'd0; cur_max = 3'd0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    screen_d  = screen_q;
    pos_d     = pos_q;
    plus_n_d  = 1'b1;
    minus_n_d = 1'b1;
    blink_d   = blink_q;
    tmo_d     = tmo_q;
    blk_cnt_d = blk_cnt_q;

    case (state_q)
      ST_VIEW: begin
        pos_d     = 3'd0;
        tmo_d     = '0;
        blk_cnt_d = '0;
        blink_d   = 1'b1;
        if (p_mode) begin
          screen_d = screen_q + 2'd1;
        end else if (p_edit && (screen_q != 2'd3)) begin
          state_d = ST_EDIT;
          pos_d   = cur_min;
        end
      end

      ST_EDIT: begin
        if (blk_cnt_q == BLK_LAST) begin
          blk_cnt_d = '0;
          blink_d   = ~blink_q;
        end else begin
          blk_cnt_d = blk_cnt_q + BW'(1);
        end
        tmo_d = any_press ? '0 : (tmo_q + TW'(1));

        if (p_mode || p_edit) begin
          state_d   = ST_VIEW;
          pos_d     = 3'd0;
          blk_cnt_d = '0;
          blink_d   = 1'b1;
        end else if (p_left && p_right) begin
          // Opposing moves cancel, and the pulse stays suppressed as for any move.
          pos_d = pos_q;
        end else if (p_right) begin
          pos_d     = (pos_q == cur_max) ? cur_min : (pos_q + 3'd1);
          blk_cnt_d = '0;
          blink_d   = 1'b1;
        end else if (p_left) begin
          pos_d     = (pos_q == cur_min) ? cur_max : (pos_q - 3'd1);
          blk_cnt_d = '0;
          blink_d   = 1'b1;
        end else if (p_plus && !p_minus) begin
          plus_n_d = 1'b0;
        end else if (p_minus && !p_plus) begin
          minus_n_d = 1'b0;
        end

        if (!any_press && (tmo_q == TMO_LAST)) begin
          state_d   = ST_VIEW;
          pos_d     = 3'd0;
          tmo_d     = '0;
          blk_cnt_d = '0;
          blink_d   = 1'b1;
        end
      end

      default: state_d = ST_VIEW;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_VIEW;
      screen_q  <= 2'd0;
      pos_q     <= 3'd0;
      plus_n_q  <= 1'b1;
      minus_n_q <= 1'b1;
      blink_q   <= 1'b1;
      tmo_q     <= '0;
      blk_cnt_q <= '0;
      key_q     <= 6'h3F;
    end else begin
      state_q   <= state_d;
      screen_q  <= screen_d;
      pos_q     <= pos_d;
      plus_n_q  <= plus_n_d;
      minus_n_q <= minus_n_d;
      blink_q   <= blink_d;
      tmo_q     <= tmo_d;
      blk_cnt_q <= blk_cnt_d;
      key_q     <= key_d;
    end
  end

  assign screen   = screen_q;
  assign EditMode = (state_q == ST_EDIT);
  assign EditPos  = pos_q;
  assign PlusN    = plus_n_q;
  assign MinusN   = minus_n_q;
  assign Blink    = blink_q;

endmodule

// File: tb/tb_edit_sequencer.sv
// Bench for edit_sequencer: directed scenarios plus random key traffic, scored against a queue-fed reference model.
module tb_edit_sequencer;

  localparam int TMO  = 16;
  localparam int BDIV = 3;

  localparam logic [5:0] K_NONE  = 6'h3F;
  localparam logic [5:0] K_MODE  = 6'h1F;
  localparam logic [5:0] K_EDIT  = 6'h2F;
  localparam logic [5:0] K_LEFT  = 6'h37;
  localparam logic [5:0] K_RIGHT = 6'h3B;
  localparam logic [5:0] K_PLUS  = 6'h3D;
  localparam logic [5:0] K_PM    = 6'h3C;
  localparam logic [5:0] K_RP    = 6'h39;

  logic clk = 1'b0;
  logic reset;
  logic KeyMode, KeyEdit, KeyLeft, KeyRight, KeyPlus, KeyMinus;
  logic [1:0] screen;
  logic       EditMode;
  logic [2:0] EditPos;
  logic       PlusN, MinusN, Blink;

  typedef struct packed {
    logic [1:0] scr;
    logic       em;
    logic [2:0] pos;
    logic       pn;
    logic       mn;
    logic       bl;
  } out_t;

  out_t exp_q[$];
  out_t act;
  int vectors = 0;
  int miscompares = 0;

  edit_sequencer #(.TIMEOUT(TMO), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .reset(reset),
    .KeyMode(KeyMode), .KeyEdit(KeyEdit), .KeyLeft(KeyLeft),
    .KeyRight(KeyRight), .KeyPlus(KeyPlus), .KeyMinus(KeyMinus),
    .screen(screen), .EditMode(EditMode), .EditPos(EditPos),
    .PlusN(PlusN), .MinusN(MinusN), .Blink(Blink)
  );

  always #5 clk = ~clk;
  assign act = {screen, EditMode, EditPos, PlusN, MinusN, Blink};

  // Reference model: cursor ranges as tables, blink/idle as "edges since last event".
  int   min_tab[4] = '{2, 0, 1, 0};
  int   max_tab[4] = '{7, 7, 4, 0};
  bit   m_edit;
  int   m_scr, m_pos, m_idle, m_since;
  bit   m_pn, m_mn;
  logic [5:0] m_prev;

  task automatic model_reset();
    m_edit = 0; m_scr = 0; m_pos = 0; m_idle = 0; m_since = 0;
    m_pn = 1; m_mn = 1; m_prev = K_NONE;
  endtask

  task automatic model_leave();
    m_edit = 0; m_pos = 0; m_idle = 0; m_since = 0;
  endtask

  task automatic model_step(input logic [5:0] k);
    logic [5:0] pr;
    pr = m_prev & ~k;
    m_prev = k;
    m_pn = 1; m_mn = 1;
    if (!m_edit) begin
      if (pr[5]) m_scr = (m_scr + 1) % 4;
      else if (pr[4] && m_scr != 3) begin
        m_edit = 1; m_pos = min_tab[m_scr]; m_idle = 0; m_since = 0;
      end
    end else begin
      m_since++;
      if (pr[5] || pr[4]) model_leave();
      else if (pr != 6'd0) begin
        m_idle = 0;
        if (pr[3] && pr[2]) ;
        else if (pr[2]) begin
          m_pos = (m_pos == max_tab[m_scr]) ? min_tab[m_scr] : m_pos + 1; m_since = 0;
        end else if (pr[3]) begin
          m_pos = (m_pos == min_tab[m_scr]) ? max_tab[m_scr] : m_pos - 1; m_since = 0;
        end else if (pr[1] && !pr[0]) m_pn = 0;
        else if (pr[0] && !pr[1]) m_mn = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) model_leave();
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    o.scr = 2'(m_scr);
    o.em  = m_edit;
    o.pos = 3'(m_pos);
    o.pn  = m_pn;
    o.mn  = m_mn;
    o.bl  = m_edit ? (((m_since / BDIV) % 2) == 0) : 1'b1;
    return o;
  endfunction

  task automatic drive(input logic [5:0] k);
    @(negedge clk);
    #1;
    {KeyMode, KeyEdit, KeyLeft, KeyRight, KeyPlus, KeyMinus} = k;
    model_step(k);
    exp_q.push_back(model_out());
  endtask

  task automatic press(input logic [5:0] k);
    drive(k);
    drive(K_NONE);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " screen"}, int'(screen), 0);
    chk({tag, " EditMode"}, int'(EditMode), 0);
    chk({tag, " EditPos"}, int'(EditPos), 0);
    chk({tag, " PlusN"}, int'(PlusN), 1);
    chk({tag, " MinusN"}, int'(MinusN), 1);
    chk({tag, " Blink"}, int'(Blink), 1);
  endtask

  // Monitor: one expected record per clock edge while out of reset.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL scoreboard t=%0t got scr=%0d em=%0b pos=%0d pn=%0b mn=%0b bl=%0b expected scr=%0d em=%0b pos=%0d pn=%0b mn=%0b bl=%0b",
                   $time, act.scr, act.em, act.pos, act.pn, act.mn, act.bl,
                   e.scr, e.em, e.pos, e.pn, e.mn, e.bl);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows, first_low;
    logic [5:0] k;
    int r;

    reset = 1'b0;
    {KeyMode, KeyEdit, KeyLeft, KeyRight, KeyPlus, KeyMinus} = K_NONE;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      press(K_MODE);
      chk("mode screen", int'(screen), (i + 1) % 4);
      chk("mode EditMode", int'(EditMode), 0);
      chk("mode PlusN", int'(PlusN), 1);
    end

    press(K_MODE);
    press(K_MODE);
    press(K_EDIT);
    chk("edit scr2 EditMode", int'(EditMode), 1);
    chk("edit scr2 EditPos", int'(EditPos), 1);
    for (int i = 0; i < 4; i++) begin
      press(K_RIGHT);
      chk("right EditPos", int'(EditPos), (i == 3) ? 1 : i + 2);
    end
    press(K_LEFT);
    chk("left wrap EditPos", int'(EditPos), 4);

    lows = 0; first_low = -1;
    for (int i = 0; i < 12; i++) begin
      drive(K_PLUS);
      @(posedge clk);
      #2;
      if (!PlusN) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
    end
    chk("held plus pulse count", lows, 1);
    chk("held plus latency", first_low, 0);
    drive(K_NONE);

    lows = 0;
    drive(K_PM);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      if (!PlusN || !MinusN) lows++;
      if (i < 2) drive(K_PM);
    end
    chk("plus+minus no pulse", lows, 0);
    drive(K_NONE);
    drive(K_RP);
    @(posedge clk);
    #2;
    chk("right+plus EditPos", int'(EditPos), 1);
    chk("right+plus PlusN", int'(PlusN), 1);
    drive(K_NONE);

    press(K_MODE);
    drive(K_EDIT);
    @(posedge clk);
    #2;
    chk("timeout entry EditMode", int'(EditMode), 1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      drive(K_NONE);
      @(posedge clk);
      #2;
      if (!EditMode) begin n = i; break; end
    end
    chk("timeout cycles", n, TMO);

    drive(K_EDIT);
    repeat (9) drive(K_NONE);
    drive(K_LEFT);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      drive(K_NONE);
      @(posedge clk);
      #2;
      if (!EditMode) begin n = i; break; end
    end
    chk("timeout restart cycles", n, TMO);

    press(K_MODE);
    chk("screen 3", int'(screen), 3);
    press(K_EDIT);
    chk("screen3 edit ignored", int'(EditMode), 0);
    press(K_MODE);
    press(K_EDIT);
    chk("scr0 entry EditPos", int'(EditPos), 2);
    repeat (3) press(K_RIGHT);
    chk("scr0 EditPos 5", int'(EditPos), 5);
    drive(K_PLUS);
    @(posedge clk);
    #3;
    chk("pulse before reset", int'(PlusN), 0);
    reset = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    exp_q.delete();
    model_reset();
    {KeyMode, KeyEdit, KeyLeft, KeyRight, KeyPlus, KeyMinus} = K_NONE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;

    for (int blk = 0; blk < 120; blk++) begin
      if (blk % 7 == 3) begin
        repeat (20) drive(K_NONE);
      end else begin
        for (int c = 0; c < 25; c++) begin
          r = int'($urandom_range(0, 99));
          k = K_NONE;
          if (r < 3) k[5] = 1'b0;
          else if (r < 8) k[4] = 1'b0;
          if ($urandom_range(0, 4) == 0) k[3] = 1'b0;
          if ($urandom_range(0, 4) == 0) k[2] = 1'b0;
          if ($urandom_range(0, 3) == 0) k[1] = 1'b0;
          if ($urandom_range(0, 3) == 0) k[0] = 1'b0;
          drive(k);
        end
      end
    end
    drive(K_NONE);
    @(posedge clk);
    #3;
    chk("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
